// File: rtl/asip_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access path.
package asip_mem_pkg;

  localparam int NBEATS     = 4;
  localparam int BEAT_BYTES = 4;

  typedef logic [$clog2(NBEATS)-1:0] beat_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_beat_assembler.sv
// Collects load beats into a full-width buffer; merged shows the buffer with the beat
// currently being acknowledged already folded in, so completion can write back that same edge.
module mem_beat_assembler
  import asip_mem_pkg::*;
#(
  parameter int BEAT_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  beat_idx_t         beat,
  input  logic [BEAT_W-1:0] rdata,
  output logic [DATA_W-1:0] merged
);

  logic [DATA_W-1:0] buffer;

  always_comb begin
    merged = buffer;
    if (wr_en) merged[BEAT_W*beat +: BEAT_W] = rdata;
  end

  // Clearing at start of every access is what zero-extends scalar loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer <= '0;
    end else if (clear) begin
      buffer <= '0;
    end else if (wr_en) begin
      buffer <= merged;
    end
  end

endmodule

// File: rtl/pipeline_mem_access.sv
// MEM stage: runs scalar (1-beat) and vector (4-beat) loads/stores over a 32-bit req/ack
// port, stalls upstream while an access is in flight, and drives the MEM/WB register.
module pipeline_mem_access
  import asip_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 32,
  parameter int DATA_W = 128,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rmem,
  input  logic              wmem,
  input  logic              wreg,
  input  logic [DATA_W-1:0] alures,
  input  logic              vf,
  input  logic [DEST_W-1:0] dest,
  input  logic [DATA_W-1:0] st_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_wreg,
  output logic [DEST_W-1:0] wb_dest,
  output logic              wb_vf,
  output logic [DATA_W-1:0] wb_data
);

  mem_state_t        state;
  beat_idx_t         beat;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] st_q;
  logic              op_store;
  logic              op_vf;
  logic              op_wreg;
  logic [DEST_W-1:0] op_dest;

  logic              busy;
  logic              mem_op;
  logic              beat_ack;
  logic              last_beat;
  logic              done;
  logic [DATA_W-1:0] merged;

  assign busy      = (state == BUSY);
  assign mem_op    = rmem | wmem;
  assign beat_ack  = busy & mem_ack;
  assign last_beat = (beat == (op_vf ? beat_idx_t'(NBEATS - 1) : beat_idx_t'(0)));
  assign done      = beat_ack & last_beat;

  // Gated by reset so stall drops at once even if a mem op is still presented upstream.
  assign stall     = rst & (busy ? ~done : mem_op);

  assign mem_req   = busy;
  assign mem_we    = busy & op_store;
  assign mem_addr  = base + ADDR_W'(beat) * ADDR_W'(BEAT_BYTES);
  assign mem_wdata = st_q[BEAT_W*beat +: BEAT_W];

  mem_beat_assembler #(
    .BEAT_W(BEAT_W),
    .DATA_W(DATA_W)
  ) u_assembler (
    .clk   (clk),
    .rst   (rst),
    .clear (~busy & mem_op),
    .wr_en (beat_ack & ~op_store),
    .beat  (beat),
    .rdata (mem_rdata),
    .merged(merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat     <= '0;
      base     <= '0;
      st_q     <= '0;
      op_store <= 1'b0;
      op_vf    <= 1'b0;
      op_wreg  <= 1'b0;
      op_dest  <= '0;
      wb_wreg  <= 1'b0;
      wb_dest  <= '0;
      wb_vf    <= 1'b0;
      wb_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state    <= BUSY;
            op_store <= wmem;
            op_vf    <= vf;
            op_wreg  <= wreg;
            op_dest  <= dest;
            base     <= {alures[ADDR_W-1:2], 2'b00};
            st_q     <= st_data;
            beat     <= '0;
            wb_wreg  <= 1'b0;
          end else begin
            wb_wreg <= wreg;
            wb_dest <= dest;
            wb_vf   <= vf;
            wb_data <= alures;
          end
        end
        BUSY: begin
          wb_wreg <= 1'b0;
          if (beat_ack) begin
            beat <= beat + beat_idx_t'(1);
            if (last_beat) begin
              state   <= IDLE;
              beat    <= '0;
              wb_wreg <= op_wreg & ~op_store;
              wb_dest <= op_dest;
              wb_vf   <= op_vf;
              wb_data <= op_store ? '0 : merged;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
